encoder_paddle: RTL
===================

# encoder_paddle

Digital replacement for the analog 555 paddle circuit, one instance per player. Decodes a quadrature rotary encoder into a saturating 8-bit paddle position. It answers each falling edge of `PAD_TRG_N` from `pongtop` with a non-retriggerable high pulse on `PAD_OUT`; the pulse width encodes the position. `PAD_OUT` is routed through the standard input synchronizer into `pongtop` as `PAD1_OUT`/`PAD2_OUT`. The whole block runs synchronously on the 14.318 MHz drive clock.

## Interface

Parameters:
- `FILT_LEN`, default 64: `CLK_DRV` cycles an encoder input must be stable before acceptance (≥2).
- `POS_MAX`, default 255: upper position limit (≤255).
- `POS_INIT`, default 128: position after reset.
- `PULSE_MIN`, default 14545: pulse width at position 0, in cycles (~16 lines).
- `STEP`, default 827: extra pulse cycles per position count.
- `ACCEL_WIN`, default 14318: acceleration window in cycles (1 ms); used only with the macro.

Ports:
- `CLK_DRV`  in  1: drive clock, 14.318 MHz.
- `RESET`  in  1: asynchronous, active-high reset.
- `ENC_A`  in  1: encoder phase A, already synchronized to `CLK_DRV`.
- `ENC_B`  in  1: encoder phase B, already synchronized.
- `PAD_TRG_N`  in  1: trigger from `pongtop`, active-low, same clock domain.
- `PAD_OUT`  out  1: monostable output pulse.
- `POS`  out  8: current position, for debug and LEDs.
- `ENC_ERR`  out  1: one-cycle strobe on an illegal quadrature transition.

## Operation

- **Filter.** A separate counter runs for each phase. The raw input must differ from the filtered value for `FILT_LEN` consecutive cycles; the filtered value then updates. Any reversion clears that counter.
- **Decoder.** Compares the previous and current filtered {A,B} each cycle.
  - Gray sequence 00→01→11→10→00 is +1; the reverse is −1.
  - No change does nothing.
  - Both bits changed: position is unchanged and `ENC_ERR` pulses.
- **Position.** `POS` saturates at 0 and `POS_MAX`. A step that would cross a limit clamps to it; no wrap-around.
- **Pulse FSM**, states IDLE and PULSE.
  - `PAD_TRG_N` is registered each cycle. A falling edge is detected when the previous sample is 1 and the current sample is 0.
  - IDLE + edge: snapshot `POS`, load counter = `PULSE_MIN + POS*STEP`, go to PULSE.
  - PULSE: decrement the counter each cycle. When the counter reaches 1, return to IDLE.
  - An edge during PULSE is ignored (non-retriggerable).
  - Position changes during PULSE do not alter the current pulse.
  - Holding `PAD_TRG_N` low produces exactly one pulse.
- **Width.** The counter is `$clog2(PULSE_MIN + POS_MAX*STEP + 1)` bits (18 with defaults). The product is computed unsigned, with no truncation.
- `PAD_OUT` = (state == PULSE), registered.

## Timing

- **Reset values.** `PAD_OUT`=0, `POS`=`POS_INIT`, `ENC_ERR`=0, state IDLE, filters = {1,1}, counters 0.
- **Reset mid-pulse.** `PAD_OUT` drops asynchronously. No pulse resumes after reset release until a new falling edge arrives.
- **Trigger latency.** Edge sampled at cycle N, so `PAD_OUT` rises at N+1. It stays high for exactly `PULSE_MIN + pos*STEP` cycles.
- **Encoder latency.** The filtered value updates `FILT_LEN` cycles after the raw change. `POS` and `ENC_ERR` update one cycle later.
- **Simultaneous events.** A trigger edge in the same cycle as a `POS` update uses the pre-update `POS`.
- **Sustained rate.** One position step per `FILT_LEN` cycles.

## Configuration

- **`ENC_PADDLE_ACCEL_EN` defined:** a free-running counter measures cycles since the last valid step.
  - A valid step within `ACCEL_WIN` cycles of the previous one moves `POS` by ±4 instead of ±1, still clamped.
  - Illegal transitions do not reset the window.
  - After reset the first step is always ±1.
- **Not defined:** every valid step is ±1, no window counter is synthesized, and `ACCEL_WIN` is unused.

## Test plan

- **Reset and pulse width:** reset, then `PAD_TRG_N` 1→0 → `POS`=128, `PAD_OUT` high one cycle after the edge for 14545+128·827=120401 cycles, then low.
- **Saturation:** 300 clockwise Gray steps spaced 100 cycles apart, then a trigger → `POS`=255, pulse width 225430 cycles. Then 300 counter-clockwise steps → `POS`=0, width 14545.
- **Filter and illegal transition:** A glitch held for 63 cycles → `POS` unchanged. {A,B} 00→11 held for 64 cycles → `ENC_ERR` high for exactly one cycle, `POS` unchanged.
- **Non-retrigger and snapshot:** trigger, then a second falling edge at +1000 cycles plus 5 clockwise steps during the pulse → a single pulse of the original width. The next trigger uses `POS`=133.
- **Reset mid-pulse:** assert `RESET` 500 cycles into a pulse → `PAD_OUT` low immediately, `POS`=128. No pulse after release until a new edge.
- **Acceleration (macro on):** steps 1000 cycles apart from `POS`=128 → 129, 133, 137. Steps 20000 apart → +1 each.

Source files
------------

// File: rtl/encoder_paddle_if.sv
`default_nettype none
// ============================================================
// Module : encoder_paddle_if
// Desc   : Encoder phases, paddle trigger and paddle outputs.
// Rev    : 1.0
// ============================================================
interface encoder_paddle_if;
  logic       ENC_A;
  logic       ENC_B;
  logic       PAD_TRG_N;
  logic       PAD_OUT;
  logic [7:0] POS;
  logic       ENC_ERR;

  modport slave  (input ENC_A, ENC_B, PAD_TRG_N, output PAD_OUT, POS, ENC_ERR);
  modport master (output ENC_A, ENC_B, PAD_TRG_N, input PAD_OUT, POS, ENC_ERR);
endinterface
`default_nettype wire

// File: rtl/encoder_paddle.sv
`default_nettype none
// ============================================================
// Module : encoder_paddle
// Desc   : Quadrature encoder to saturating paddle position with a
//          position-width monostable pulse. ENC_PADDLE_ACCEL_EN adds
//          +/-4 steps for fast rotation.
// Rev    : 1.0
// ============================================================
module encoder_paddle #(
  parameter int FILT_LEN  = 64,
  parameter int POS_MAX   = 255,
  parameter int POS_INIT  = 128,
  parameter int PULSE_MIN = 14545,
  parameter int STEP      = 827,
  parameter int ACCEL_WIN = 14318
) (
  input  logic            CLK_DRV,
  input  logic            RESET,
  encoder_paddle_if.slave pad
);

  localparam int FILT_W = $clog2(FILT_LEN);
  localparam int CNT_W  = $clog2(PULSE_MIN + POS_MAX * STEP + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, PULSE = 1'b1} state_t;

  logic [1:0]             w_raw;
  logic [1:0]             filt_q, filt_d;
  logic [1:0][FILT_W-1:0] fcnt_q, fcnt_d;
  logic [1:0]             ab_prev_q;
  logic [1:0]             w_delta;
  logic                   w_up, w_dn;
  logic [2:0]             w_mag;
  logic [8:0]             w_sum;
  logic [7:0]             pos_q, pos_d;
  logic                   enc_err_q, enc_err_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       pcnt_q, pcnt_d;
  logic                   trg_q, trg_prev_q;
  logic                   w_trg_fall;
  logic                   pad_out_q, pad_out_d;

  // Gray code 00,01,11,10 mapped onto a 0..3 ring index
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  assign w_raw = {pad.ENC_A, pad.ENC_B};

  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (w_raw[i] == filt_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] == FILT_W'(FILT_LEN - 1)) begin
        filt_d[i] = w_raw[i];
        fcnt_d[i] = '0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
  end

  assign w_delta = gray_idx(filt_q) - gray_idx(ab_prev_q);
  assign w_up    = (w_delta == 2'd1);
  assign w_dn    = (w_delta == 2'd3);

`ifdef ENC_PADDLE_ACCEL_EN
  localparam int WIN_W = $clog2(ACCEL_WIN + 1);

  logic [WIN_W-1:0] win_q, win_d;

  // Saturates at ACCEL_WIN, which also marks "no recent step" after reset
  always_comb begin
    win_d = win_q;
    if (w_up || w_dn) begin
      win_d = '0;
    end else if (win_q != WIN_W'(ACCEL_WIN)) begin
      win_d = win_q + 1'b1;
    end
  end

  assign w_mag = (win_q < WIN_W'(ACCEL_WIN)) ? 3'd4 : 3'd1;

  always_ff @(posedge CLK_DRV or posedge RESET) begin
    if (RESET) begin
      win_q <= WIN_W'(ACCEL_WIN);
    end else begin
      win_q <= win_d;
    end
  end
`else
  logic unused_accel_win;
  assign unused_accel_win = ^ACCEL_WIN;
  assign w_mag            = 3'd1;
`endif

  always_comb begin
    pos_d     = pos_q;
    enc_err_d = (w_delta == 2'd2);
    w_sum     = {1'b0, pos_q} + {6'b0, w_mag};
    if (w_up) begin
      pos_d = (w_sum > 9'(POS_MAX)) ? 8'(POS_MAX) : w_sum[7:0];
    end else if (w_dn) begin
      pos_d = (pos_q < {5'b0, w_mag}) ? 8'd0 : (pos_q - {5'b0, w_mag});
    end
  end

  assign w_trg_fall = trg_prev_q & ~trg_q;

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      IDLE: begin
        if (w_trg_fall) begin
          pcnt_d  = CNT_W'(32'(PULSE_MIN) + 32'(pos_q) * 32'(STEP));
          state_d = PULSE;
        end
      end
      PULSE: begin
        pcnt_d = pcnt_q - 1'b1;
        if (pcnt_q == CNT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    pad_out_d = (state_d == PULSE);
  end

  // Trigger samples reset low so a trigger held low across reset cannot fire
  always_ff @(posedge CLK_DRV or posedge RESET) begin
    if (RESET) begin
      filt_q     <= 2'b11;
      fcnt_q     <= '0;
      ab_prev_q  <= 2'b11;
      pos_q      <= 8'(POS_INIT);
      enc_err_q  <= 1'b0;
      state_q    <= IDLE;
      pcnt_q     <= '0;
      trg_q      <= 1'b0;
      trg_prev_q <= 1'b0;
      pad_out_q  <= 1'b0;
    end else begin
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      ab_prev_q  <= filt_q;
      pos_q      <= pos_d;
      enc_err_q  <= enc_err_d;
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      trg_q      <= pad.PAD_TRG_N;
      trg_prev_q <= trg_q;
      pad_out_q  <= pad_out_d;
    end
  end

  assign pad.PAD_OUT = pad_out_q;
  assign pad.POS     = pos_q;
  assign pad.ENC_ERR = enc_err_q;

endmodule
`default_nettype wire
